// File: rtl/timing_gen_mc.sv
// timing_gen_mc: parametrised radar timing generator.
// Emits CPI begin/end strobes, a PRI transmit pulse and N_SYNC delayed sync
// pulses. Frame geometry is written into shadow registers with cfg_load and
// copied into the active set only in the LOAD state, i.e. at CPI boundaries.
// All outputs are registered from the current FSM/counter state, so they lag
// the internal state by one cycle.
// Optional feature macro: PRI_STAGGER_EN (odd PRIs use cfg_pri_period_b).
module timing_gen_mc #(
    parameter int CNT_W      = 32,
    parameter int NUM_W      = 10,
    parameter int N_SYNC     = 4,
    parameter int DEF_PERIOD = 100,
    parameter int DEF_WIDTH  = 10,
    parameter int DEF_NUM    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        cfg_pri_period,
`ifdef PRI_STAGGER_EN
    input  logic [CNT_W-1:0]        cfg_pri_period_b,
`endif
    input  logic [CNT_W-1:0]        cfg_pri_width,
    input  logic [NUM_W-1:0]        cfg_pri_num,
    input  logic [CNT_W-1:0]        cfg_cpi_gap,
    input  logic [N_SYNC*CNT_W-1:0] cfg_sync_delay,
    input  logic [15:0]             cfg_sync_width,
    output logic                    cpib,
    output logic                    cpie,
    output logic                    pri,
    output logic [N_SYNC-1:0]       sync,
    output logic [NUM_W-1:0]        pri_idx,
    output logic [CNT_W-1:0]        cpi_cnt,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
    localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                    state_r, state_nx_s;
    logic [CNT_W-1:0]          pri_cnt_r, pri_cnt_nx_s;
    logic [NUM_W-1:0]          pri_idx_r, pri_idx_nx_s;
    logic [CNT_W-1:0]          gap_cnt_r, gap_cnt_nx_s;

    logic [CNT_W-1:0]          sh_period_r, sh_width_r, sh_gap_r;
    logic [NUM_W-1:0]          sh_num_r;
    logic [N_SYNC*CNT_W-1:0]   sh_delay_r;
    logic [15:0]               sh_sync_w_r;
    logic [CNT_W-1:0]          act_period_r, act_width_r, act_gap_r;
    logic [NUM_W-1:0]          act_num_r;
    logic [N_SYNC*CNT_W-1:0]   act_delay_r;
    logic [15:0]               act_sync_w_r;

    logic                      cfg_ok_s, load_act_s, err_set_s, err_clr_s, cpi_end_s;
    logic                      run_s, last_cnt_s, last_pri_s;
    logic [CNT_W-1:0]          cur_period_s;
    logic [CNT_W:0]            cnt_x_s, sw_x_s;
    logic [N_SYNC-1:0]         sync_s;

`ifdef PRI_STAGGER_EN
    logic [CNT_W-1:0]          sh_period_b_r, act_period_b_r;

    // Shadow/active copies of the alternate (odd PRI) period
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period_b_r  <= CNT_W'(DEF_PERIOD);
            act_period_b_r <= CNT_W'(DEF_PERIOD);
        end else begin
            if (cfg_load) sh_period_b_r <= cfg_pri_period_b;
            if (load_act_s) act_period_b_r <= sh_period_b_r;
        end
    end

    assign cur_period_s = pri_idx_r[0] ? act_period_b_r : act_period_r;
    assign cfg_ok_s = (sh_period_r >= CNT_TWO) && (sh_width_r >= CNT_ONE) &&
                      (sh_width_r < sh_period_r) && (sh_num_r >= NUM_ONE) &&
                      (sh_sync_w_r >= 16'd1) && (sh_period_b_r >= CNT_TWO) &&
                      (sh_width_r < sh_period_b_r);
`else
    assign cur_period_s = act_period_r;
    assign cfg_ok_s = (sh_period_r >= CNT_TWO) && (sh_width_r >= CNT_ONE) &&
                      (sh_width_r < sh_period_r) && (sh_num_r >= NUM_ONE) &&
                      (sh_sync_w_r >= 16'd1);
`endif

    // Shadow registers: written by cfg_load at any time, never read by the running CPI
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period_r <= CNT_W'(DEF_PERIOD);
            sh_width_r  <= CNT_W'(DEF_WIDTH);
            sh_num_r    <= NUM_W'(DEF_NUM);
            sh_gap_r    <= CNT_ZERO;
            sh_delay_r  <= {(N_SYNC*CNT_W){1'b0}};
            sh_sync_w_r <= 16'd1;
        end else if (cfg_load) begin
            sh_period_r <= cfg_pri_period;
            sh_width_r  <= cfg_pri_width;
            sh_num_r    <= cfg_pri_num;
            sh_gap_r    <= cfg_cpi_gap;
            sh_delay_r  <= cfg_sync_delay;
            sh_sync_w_r <= cfg_sync_width;
        end
    end

    // Active registers: snapshot of the shadow set taken in LOAD (old values if cfg_load coincides)
    always_ff @(posedge clk) begin
        if (rst) begin
            act_period_r <= CNT_W'(DEF_PERIOD);
            act_width_r  <= CNT_W'(DEF_WIDTH);
            act_num_r    <= NUM_W'(DEF_NUM);
            act_gap_r    <= CNT_ZERO;
            act_delay_r  <= {(N_SYNC*CNT_W){1'b0}};
            act_sync_w_r <= 16'd1;
        end else if (load_act_s) begin
            act_period_r <= sh_period_r;
            act_width_r  <= sh_width_r;
            act_num_r    <= sh_num_r;
            act_gap_r    <= sh_gap_r;
            act_delay_r  <= sh_delay_r;
            act_sync_w_r <= sh_sync_w_r;
        end
    end

    assign run_s      = (state_r == ST_RUN);
    assign last_cnt_s = (pri_cnt_r == cur_period_s - CNT_ONE);
    assign last_pri_s = (pri_idx_r == act_num_r - NUM_ONE);
    assign cpi_end_s  = run_s && last_cnt_s && last_pri_s;

    // Next-state and counter update logic
    always_comb begin
        state_nx_s   = state_r;
        pri_cnt_nx_s = pri_cnt_r;
        pri_idx_nx_s = pri_idx_r;
        gap_cnt_nx_s = gap_cnt_r;
        load_act_s   = 1'b0;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nx_s = ST_LOAD;
                else        state_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                load_act_s = 1'b1;
                if (cfg_ok_s) begin
                    err_clr_s    = 1'b1;
                    state_nx_s   = ST_RUN;
                    pri_cnt_nx_s = CNT_ZERO;
                    pri_idx_nx_s = NUM_ZERO;
                end else begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_cnt_s) begin
                    pri_cnt_nx_s = CNT_ZERO;
                    if (last_pri_s) begin
                        gap_cnt_nx_s = CNT_ZERO;
                        if (!enable)                 state_nx_s = ST_IDLE;
                        else if (act_gap_r == CNT_ZERO) state_nx_s = ST_LOAD;
                        else                         state_nx_s = ST_GAP;
                    end else begin
                        pri_idx_nx_s = pri_idx_r + NUM_ONE;
                    end
                end else begin
                    pri_cnt_nx_s = pri_cnt_r + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == act_gap_r - CNT_ONE) begin
                    if (enable) state_nx_s = ST_LOAD;
                    else        state_nx_s = ST_IDLE;
                end else begin
                    gap_cnt_nx_s = gap_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pri_cnt_r <= CNT_ZERO;
            pri_idx_r <= NUM_ZERO;
            gap_cnt_r <= CNT_ZERO;
        end else begin
            state_r   <= state_nx_s;
            pri_cnt_r <= pri_cnt_nx_s;
            pri_idx_r <= pri_idx_nx_s;
            gap_cnt_r <= gap_cnt_nx_s;
        end
    end

    // Sync windows compared one bit wider so delay+width cannot wrap
    assign cnt_x_s = {1'b0, pri_cnt_r};
    assign sw_x_s  = {{(CNT_W-15){1'b0}}, act_sync_w_r};

    for (genvar k = 0; k < N_SYNC; k++) begin : g_sync
        logic [CNT_W:0] lo_s, hi_s;
        assign lo_s      = {1'b0, act_delay_r[k*CNT_W +: CNT_W]};
        assign hi_s      = lo_s + sw_x_s;
        assign sync_s[k] = run_s && (cnt_x_s >= lo_s) && (cnt_x_s < hi_s);
    end

    // Registered outputs decoded from the current state and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cpib    <= 1'b0;
            cpie    <= 1'b0;
            pri     <= 1'b0;
            sync    <= {N_SYNC{1'b0}};
            pri_idx <= NUM_ZERO;
            cpi_cnt <= CNT_ZERO;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cpib    <= run_s && (pri_idx_r == NUM_ZERO) && (pri_cnt_r == CNT_ZERO);
            cpie    <= cpi_end_s;
            pri     <= run_s && (pri_cnt_r < act_width_r);
            sync    <= sync_s;
            pri_idx <= pri_idx_r;
            cpi_cnt <= cpi_end_s ? (cpi_cnt + CNT_ONE) : cpi_cnt;
            busy    <= (state_r != ST_IDLE);
            if (err_set_s)      cfg_err <= 1'b1;
            else if (err_clr_s) cfg_err <= 1'b0;
            else                cfg_err <= cfg_err;
        end
    end

endmodule

// File: tb/tb_timing_gen_mc.sv
// Self-checking bench for timing_gen_mc: directed scenarios plus a randomized
// run, all checked cycle by cycle against a frame-level reference model that
// derives PRI index/offset from the elapsed time inside the CPI.
module tb_timing_gen_mc;

    localparam int CW = 32;
    localparam int NW = 10;
    localparam int NS = 4;
`ifdef PRI_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           cfg_load = 1'b0;
    logic [CW-1:0]  cfg_pri_period = 32'd100;
    logic [CW-1:0]  cfg_pri_period_b = 32'd100;
    logic [CW-1:0]  cfg_pri_width = 32'd10;
    logic [NW-1:0]  cfg_pri_num = 10'd16;
    logic [CW-1:0]  cfg_cpi_gap = 32'd0;
    logic [NS*CW-1:0] cfg_sync_delay = '0;
    logic [15:0]    cfg_sync_width = 16'd1;
    logic           cpib, cpie, pri, busy, cfg_err;
    logic [NS-1:0]  sync;
    logic [NW-1:0]  pri_idx;
    logic [CW-1:0]  cpi_cnt;

    always #5 clk = ~clk;

    timing_gen_mc dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
        .cfg_pri_period(cfg_pri_period),
`ifdef PRI_STAGGER_EN
        .cfg_pri_period_b(cfg_pri_period_b),
`endif
        .cfg_pri_width(cfg_pri_width), .cfg_pri_num(cfg_pri_num),
        .cfg_cpi_gap(cfg_cpi_gap), .cfg_sync_delay(cfg_sync_delay),
        .cfg_sync_width(cfg_sync_width),
        .cpib(cpib), .cpie(cpie), .pri(pri), .sync(sync), .pri_idx(pri_idx),
        .cpi_cnt(cpi_cnt), .busy(busy), .cfg_err(cfg_err)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    int     m_mode = 0;              // 0 idle, 1 load, 2 run, 3 gap
    longint m_pos = 0, m_gpos = 0;
    longint sh_p = 100, sh_pb = 100, sh_w = 10, sh_g = 0, sh_n = 16, sh_sw = 1;
    longint sh_d[NS];
    longint ac_p = 100, ac_pb = 100, ac_w = 10, ac_g = 0, ac_n = 16, ac_sw = 1;
    longint ac_d[NS];
    int     m_hold = 0;
    bit     m_err = 1'b0;
    logic   e_cpib = 1'b0, e_cpie = 1'b0, e_pri = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [NS-1:0] e_sync = '0;
    logic [NW-1:0] e_idx = '0;
    logic [CW-1:0] e_cpi = '0;

    wire [50:0] dut_vec = {cpib, cpie, pri, sync, busy, cfg_err, pri_idx, cpi_cnt};
    wire [50:0] exp_vec = {e_cpib, e_cpie, e_pri, e_sync, e_busy, e_err, e_idx, e_cpi};

    function automatic longint per_of(int i);
        return (STAG && (i % 2 == 1)) ? ac_pb : ac_p;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_edge();
        longint t;
        int     i;
        bit     last;
        int     old_mode;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_gpos = 0; m_hold = 0; m_err = 1'b0;
            sh_p = 100; sh_pb = 100; sh_w = 10; sh_g = 0; sh_n = 16; sh_sw = 1;
            for (int k = 0; k < NS; k++) sh_d[k] = 0;
            e_cpib = 1'b0; e_cpie = 1'b0; e_pri = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            e_sync = '0; e_idx = '0; e_cpi = '0;
            return;
        end
        old_mode = m_mode;
        e_cpib = 1'b0; e_cpie = 1'b0; e_pri = 1'b0; e_sync = '0;
        e_busy = (old_mode != 0);
        e_idx  = NW'(m_hold);
        if (old_mode == 2) begin
            t = m_pos; i = 0;
            while (t >= per_of(i)) begin t -= per_of(i); i++; end
            last   = (i == ac_n - 1) && (t == per_of(i) - 1);
            e_pri  = (t < ac_w);
            e_cpib = (m_pos == 0);
            e_cpie = last;
            for (int k = 0; k < NS; k++) e_sync[k] = (t >= ac_d[k]) && (t < ac_d[k] + ac_sw);
            e_idx  = NW'(i);
            m_hold = i;
            if (last) begin
                e_cpi  = e_cpi + 32'd1;
                m_gpos = 0;
                m_mode = !enable ? 0 : (ac_g == 0 ? 1 : 3);
            end else begin
                m_pos++;
            end
        end else if (old_mode == 1) begin
            ac_p = sh_p; ac_pb = sh_pb; ac_w = sh_w; ac_g = sh_g; ac_n = sh_n; ac_sw = sh_sw;
            for (int k = 0; k < NS; k++) ac_d[k] = sh_d[k];
            if (sh_p >= 2 && sh_w >= 1 && sh_w < sh_p && sh_n >= 1 && sh_sw >= 1 &&
                (!STAG || (sh_pb >= 2 && sh_w < sh_pb))) begin
                m_err = 1'b0; m_mode = 2; m_pos = 0;
            end else begin
                m_err = 1'b1; m_mode = 0;
            end
        end else if (old_mode == 3) begin
            if (m_gpos == ac_g - 1) m_mode = enable ? 1 : 0;
            else m_gpos++;
        end else begin
            if (enable) m_mode = 1;
        end
        e_err = m_err;
        if (cfg_load) begin
            sh_p = cfg_pri_period; sh_pb = cfg_pri_period_b; sh_w = cfg_pri_width;
            sh_g = cfg_cpi_gap; sh_n = cfg_pri_num; sh_sw = cfg_sync_width;
            for (int k = 0; k < NS; k++) sh_d[k] = cfg_sync_delay[k*CW +: CW];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    // Reset, then program a configuration (drives only)
    task automatic setup(input int p, input int pb, input int w, input int n, input int g,
                         input int d0, input int d1, input int sw);
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0;
        tick();
        rst = 1'b0;
        cfg_pri_period = CW'(p); cfg_pri_period_b = CW'(pb); cfg_pri_width = CW'(w);
        cfg_pri_num = NW'(n); cfg_cpi_gap = CW'(g); cfg_sync_width = 16'(sw);
        cfg_sync_delay = '0;
        cfg_sync_delay[0 +: CW] = CW'(d0);
        cfg_sync_delay[CW +: CW] = CW'(d1);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; cfg_load = 1'b1;
        tick(); tick();
        checks++;
        if (dut_vec !== 51'd0) begin
            fails++; $display("FAIL reset_outputs: got %h, required 0", dut_vec);
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            fails++; $display("FAIL reset_model: got %h, required %h", dut_vec, exp_vec);
        end
        cfg_load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_basic();
        int cq[$]; int eq[$]; int s; int npri; int nsync; int first_sync;
        setup(10, 10, 2, 4, 6, 3, 0, 1);
        enable = 1'b1;
        tick();
        s = cyc;
        npri = 0; nsync = 0; first_sync = -1;
        for (int n = 0; n < 150; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL basic cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (cpib === 1'b1) cq.push_back(cyc);
            if (cpie === 1'b1) eq.push_back(cyc);
            if (cq.size() == 1) begin
                if (pri === 1'b1) npri++;
                if (sync[0] === 1'b1) begin
                    nsync++;
                    if (first_sync < 0) first_sync = cyc;
                end
            end
        end
        checks++;
        if (cq.size() < 3 || eq.size() < 1) begin
            fails++; $display("FAIL basic_strobes: cpib count %0d cpie count %0d, required >=3 and >=1", cq.size(), eq.size());
        end else begin
            checks++;
            if (cq[0] - s != 2) begin fails++; $display("FAIL basic_first_cpib: latency %0d, required 2", cq[0] - s); end
            checks++;
            if (cq[1] - cq[0] != 47 || cq[2] - cq[1] != 47) begin
                fails++; $display("FAIL basic_cpib_spacing: %0d/%0d, required 47", cq[1] - cq[0], cq[2] - cq[1]);
            end
            checks++;
            if (eq[0] - cq[0] != 39) begin fails++; $display("FAIL basic_cpie_pos: %0d, required 39", eq[0] - cq[0]); end
            checks++;
            if (npri != 8) begin fails++; $display("FAIL basic_pri_count: %0d, required 8", npri); end
            checks++;
            if (nsync != 4 || first_sync - cq[0] != 3) begin
                fails++; $display("FAIL basic_sync0: count %0d offset %0d, required 4 and 3", nsync, first_sync - cq[0]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int nb; int ne; int w;
        setup(10, 10, 2, 4, 6, 3, 0, 1);
        enable = 1'b1;
        w = 0;
        while (cpib !== 1'b1 && w < 20) begin tick(); w++; end
        checks++;
        if (cpib !== 1'b1) begin fails++; $display("FAIL drop_wait_cpib: cpib %b, required 1", cpib); end
        for (int n = 0; n < 11; n++) tick();
        checks++;
        if (pri_idx !== 10'd1) begin fails++; $display("FAIL drop_pri_idx: %0d, required 1", pri_idx); end
        enable = 1'b0;
        nb = 0; ne = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL drop cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (cpib === 1'b1) nb++;
            if (cpie === 1'b1) ne++;
        end
        checks++;
        if (nb != 0 || ne != 1) begin fails++; $display("FAIL drop_strobes: cpib %0d cpie %0d, required 0 and 1", nb, ne); end
        checks++;
        if (busy !== 1'b0 || cpi_cnt !== 32'd1 || pri_idx !== 10'd3) begin
            fails++; $display("FAIL drop_final: busy %b cpi_cnt %0d pri_idx %0d, required 0 1 3", busy, cpi_cnt, pri_idx);
        end
    endtask

    task automatic test_cfg_midcpi();
        int cq[$];
        setup(10, 10, 2, 4, 6, 3, 0, 1);
        enable = 1'b1;
        for (int n = 0; n < 170; n++) begin
            cfg_load = 1'b0;
            if (n == 10) begin cfg_pri_period = 32'd20; cfg_load = 1'b1; end
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL midcfg cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (cpib === 1'b1) cq.push_back(cyc);
        end
        cfg_load = 1'b0;
        checks++;
        if (cq.size() < 3) begin
            fails++; $display("FAIL midcfg_cpib_count: %0d, required >=3", cq.size());
        end else begin
            checks++;
            if (cq[1] - cq[0] != 47 || cq[2] - cq[1] != 87) begin
                fails++; $display("FAIL midcfg_spacing: %0d/%0d, required 47/87", cq[1] - cq[0], cq[2] - cq[1]);
            end
        end
    endtask

    task automatic test_bad_cfg();
        int npri; int nbusy;
        setup(10, 10, 10, 4, 6, 3, 0, 1);
        enable = 1'b1;
        npri = 0; nbusy = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL badcfg cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (pri === 1'b1) npri++;
            if (busy === 1'b1) nbusy++;
        end
        checks++;
        if (cfg_err !== 1'b1 || npri != 0 || nbusy != 10) begin
            fails++; $display("FAIL badcfg_status: err %b pri %0d busy %0d, required 1 0 10", cfg_err, npri, nbusy);
        end
        cfg_pri_width = 32'd5; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        npri = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL fixcfg cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (pri === 1'b1) npri++;
        end
        checks++;
        if (cfg_err !== 1'b0 || npri < 10) begin
            fails++; $display("FAIL fixcfg_status: err %b pri %0d, required 0 and >=10", cfg_err, npri);
        end
    endtask

    task automatic test_num1_rst();
        int cq[$]; int ns1; int w;
        setup(10, 10, 2, 1, 0, 0, 12, 1);
        enable = 1'b1;
        ns1 = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL num1 cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (cpib === 1'b1) cq.push_back(cyc);
            if (sync[1] === 1'b1) ns1++;
        end
        checks++;
        if (cq.size() < 4 || ns1 != 0) begin
            fails++; $display("FAIL num1_counts: cpib %0d sync1 %0d, required >=4 and 0", cq.size(), ns1);
        end else begin
            checks++;
            if (cq[1] - cq[0] != 11 || cq[3] - cq[2] != 11) begin
                fails++; $display("FAIL num1_spacing: %0d/%0d, required 11", cq[1] - cq[0], cq[3] - cq[2]);
            end
        end
        w = 0;
        while (pri !== 1'b1 && w < 20) begin tick(); w++; end
        rst = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0;
        checks++;
        if (dut_vec !== 51'd0) begin fails++; $display("FAIL midpri_reset: got %h, required 0", dut_vec); end
    endtask

`ifdef PRI_STAGGER_EN
    task automatic test_stagger();
        int rq[$]; int cq[$]; logic prev;
        setup(10, 14, 2, 4, 0, 0, 0, 1);
        enable = 1'b1;
        prev = 1'b0;
        for (int n = 0; n < 110; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL stagger cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
            if (cpib === 1'b1) cq.push_back(cyc);
            if (pri === 1'b1 && prev === 1'b0) rq.push_back(cyc);
            prev = pri;
        end
        checks++;
        if (cq.size() < 2 || rq.size() < 4) begin
            fails++; $display("FAIL stagger_counts: cpib %0d rises %0d", cq.size(), rq.size());
        end else begin
            checks++;
            if (rq[1] - rq[0] != 10 || rq[2] - rq[0] != 24 || rq[3] - rq[0] != 34 || cq[1] - cq[0] != 49) begin
                fails++; $display("FAIL stagger_offsets: %0d %0d %0d spacing %0d, required 10 24 34 49",
                                  rq[1] - rq[0], rq[2] - rq[0], rq[3] - rq[0], cq[1] - cq[0]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int p;
        setup(6, 7, 2, 3, 2, 1, 4, 2);
        enable = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cfg_load = ($urandom_range(0, 29) == 0);
            if (cfg_load) begin
                p = $urandom_range(1, 12);
                cfg_pri_period   = CW'(p);
                cfg_pri_period_b = CW'($urandom_range(1, 12));
                cfg_pri_width    = CW'($urandom_range(0, p));
                cfg_pri_num      = NW'($urandom_range(0, 4));
                cfg_cpi_gap      = CW'($urandom_range(0, 5));
                cfg_sync_width   = 16'($urandom_range(0, 4));
                for (int k = 0; k < NS; k++) cfg_sync_delay[k*CW +: CW] = CW'($urandom_range(0, 13));
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                if (fails <= 30) $display("FAIL random cyc=%0d: got %h, required %h", cyc, dut_vec, exp_vec);
            end
        end
        rst = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin sh_d[k] = 0; ac_d[k] = 0; end
        test_reset();
        test_basic();
        test_enable_drop();
        test_cfg_midcpi();
        test_bad_cfg();
        test_num1_rst();
`ifdef PRI_STAGGER_EN
        test_stagger();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
